sad_best_match: RTL and testbench

- Downstream consumer of the motion-estimation PE array.
- Each cycle it accepts one row of MACRO_DIM absolute differences (one 8-bit AD per PE column) and reduces the row with a registered adder tree.
- It accumulates MACRO_DIM rows into a candidate SAD and keeps the minimum-SAD candidate over a full search window.
- On completion it reports the best SAD and the signed motion vector to the mode-decision stage.

---
 rtl/sad_best_match_if.sv | 39 +++
 rtl/sad_best_match.sv | 244 ++++++++++++++++++++++++
 tb/tb_sad_best_match.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sad_best_match_if.sv
// -----------------------------------------------------------------------------
// sad_best_match_if
// Bundles the row-stream input and the best-match result of sad_best_match.
//   start     : begin a new macroblock search (honoured only when idle)
//   ad_valid  : ad_in carries a valid row of absolute differences
//   ad_in     : MACRO_DIM packed 8-bit ADs, column c at bits [8c+7:8c]
//   busy      : search in progress (RUN or FLUSH)
//   done      : one-cycle pulse, best_* are final
//   best_sad  : minimum candidate SAD
//   best_mvx  : signed x motion vector of the best candidate
//   best_mvy  : signed y motion vector of the best candidate
// master = row producer / result consumer, slave = sad_best_match.
// -----------------------------------------------------------------------------
interface sad_best_match_if #(
    parameter int MACRO_DIM    = 16,
    parameter int SEARCH_RANGE = 8
) ();
    localparam int SAD_W = 8 + 2 * $clog2(MACRO_DIM);
    localparam int MV_W  = $clog2(2 * SEARCH_RANGE + 1) + 1;

    logic                       start;
    logic                       ad_valid;
    logic [MACRO_DIM*8-1:0]     ad_in;
    logic                       busy;
    logic                       done;
    logic [SAD_W-1:0]           best_sad;
    logic signed [MV_W-1:0]     best_mvx;
    logic signed [MV_W-1:0]     best_mvy;

    modport master (
        output start, ad_valid, ad_in,
        input  busy, done, best_sad, best_mvx, best_mvy
    );

    modport slave (
        input  start, ad_valid, ad_in,
        output busy, done, best_sad, best_mvx, best_mvy
    );
endinterface

// File: rtl/sad_best_match.sv
// -----------------------------------------------------------------------------
// sad_best_match
// Reduces each accepted row of MACRO_DIM absolute differences with a
// registered adder stage, accumulates MACRO_DIM rows into a candidate SAD and
// keeps the minimum over the (2*SEARCH_RANGE+1)^2 candidate search window,
// visited in raster order (x fastest).
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (aborts a search, no done pulse)
//   bus   : sad_best_match_if.slave (start/ad_valid/ad_in in,
//           busy/done/best_sad/best_mvx/best_mvy out)
// -----------------------------------------------------------------------------
module sad_best_match #(
    parameter int MACRO_DIM    = 16,
    parameter int SEARCH_RANGE = 8,
    parameter int SAD_W        = 8 + 2 * $clog2(MACRO_DIM)
) (
    input  logic            clk,
    input  logic            rst_n,
    sad_best_match_if.slave bus
);
    localparam int RS_W  = 8 + $clog2(MACRO_DIM);
    localparam int ROW_W = $clog2(MACRO_DIM);
    localparam int C_W   = $clog2(2 * SEARCH_RANGE + 1);
    localparam int MV_W  = C_W + 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MACRO_DIM - 1);
    localparam logic [C_W-1:0]   C_LAST   = C_W'(2 * SEARCH_RANGE);
    localparam logic [MV_W-1:0]  MV_OFS   = MV_W'(SEARCH_RANGE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    w_accept;
    logic                    w_start;
    logic                    w_row_wrap;
    logic                    w_cx_wrap;
    logic                    w_last_cand;
    logic [RS_W-1:0]         w_row_sum;

    logic [ROW_W-1:0]        r_row_cnt;
    logic [C_W-1:0]          r_cx;
    logic [C_W-1:0]          r_cy;

    // Stage-1 registers: row sum plus the tags that travel with it
    logic                    r_rs_valid;
    logic [RS_W-1:0]         r_row_sum;
    logic                    r_first_row;
    logic                    r_last_row;
    logic [C_W-1:0]          r_cand_x;
    logic [C_W-1:0]          r_cand_y;
    logic                    r_last_cand;

    logic [SAD_W-1:0]        r_acc;
    logic [SAD_W-1:0]        w_total;
    logic                    w_better;
    logic [MV_W-1:0]         w_mvx;
    logic [MV_W-1:0]         w_mvy;

    logic [SAD_W-1:0]        r_best_sad;
    logic [MV_W-1:0]         r_best_mvx;
    logic [MV_W-1:0]         r_best_mvy;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;

    assign w_accept    = bus.ad_valid && (r_state == S_RUN);
    assign w_start     = bus.start && (r_state == S_IDLE);
    assign w_row_wrap  = (r_row_cnt == ROW_LAST);
    assign w_cx_wrap   = (r_cx == C_LAST);
    assign w_last_cand = w_cx_wrap && (r_cy == C_LAST);

    // Row reduction: zero-extended sum of all column ADs, wide enough to never overflow
    always_comb begin
        w_row_sum = '0;
        for (int c = 0; c < MACRO_DIM; c++) begin
            w_row_sum = w_row_sum + RS_W'(bus.ad_in[8*c +: 8]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_accept && w_row_wrap && w_last_cand) begin
                    w_next_state = S_FLUSH;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_FLUSH: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM output decode; done follows the stage-2 processing of the final row,
    // which is exactly the FLUSH->IDLE edge
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next_state)
            S_RUN:   w_busy_nxt = 1'b1;
            S_FLUSH: w_busy_nxt = 1'b1;
            default: w_busy_nxt = 1'b0;
        endcase
        if (r_rs_valid && r_last_row && r_last_cand) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = 1'b0;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Row / candidate counters in raster order; only accepted rows advance them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
        end else if (w_start) begin
            r_row_cnt <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
        end else if (w_accept) begin
            if (w_row_wrap) begin
                r_row_cnt <= '0;
                if (w_cx_wrap) begin
                    r_cx <= '0;
                    if (r_cy == C_LAST) begin
                        r_cy <= '0;
                    end else begin
                        r_cy <= r_cy + C_W'(1);
                    end
                end else begin
                    r_cx <= r_cx + C_W'(1);
                end
            end else begin
                r_row_cnt <= r_row_cnt + ROW_W'(1);
            end
        end
    end

    // Stage 1: register the row sum and its position tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_valid  <= 1'b0;
            r_row_sum   <= '0;
            r_first_row <= 1'b0;
            r_last_row  <= 1'b0;
            r_cand_x    <= '0;
            r_cand_y    <= '0;
            r_last_cand <= 1'b0;
        end else begin
            r_rs_valid <= w_accept;
            if (w_accept) begin
                r_row_sum   <= w_row_sum;
                r_first_row <= (r_row_cnt == '0);
                r_last_row  <= w_row_wrap;
                r_cand_x    <= r_cx;
                r_cand_y    <= r_cy;
                r_last_cand <= w_last_cand;
            end
        end
    end

    // Stage 2 combinational: candidate running total, strict-less compare, MV
    always_comb begin
        if (r_first_row) begin
            w_total = SAD_W'(r_row_sum);
        end else begin
            w_total = r_acc + SAD_W'(r_row_sum);
        end
        // strict compare keeps the earlier candidate on ties
        w_better = r_rs_valid && r_last_row && (w_total < r_best_sad);
        w_mvx    = {1'b0, r_cand_x} - MV_OFS;
        w_mvy    = {1'b0, r_cand_y} - MV_OFS;
    end

    // Stage 2: candidate accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_rs_valid) begin
            r_acc <= w_total;
        end
    end

    // Best-match registers: reinitialised on an accepted start, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_sad <= '1;
            r_best_mvx <= '0;
            r_best_mvy <= '0;
        end else if (w_start) begin
            r_best_sad <= '1;
            r_best_mvx <= '0;
            r_best_mvy <= '0;
        end else if (w_better) begin
            r_best_sad <= w_total;
            r_best_mvx <= w_mvx;
            r_best_mvy <= w_mvy;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.best_sad = r_best_sad;
    assign bus.best_mvx = r_best_mvx;
    assign bus.best_mvy = r_best_mvy;
endmodule

// File: tb/tb_sad_best_match.sv
// -----------------------------------------------------------------------------
// tb_sad_best_match
// Directed self-checking bench for sad_best_match (16x16 macroblock, +/-8).
// -----------------------------------------------------------------------------
module tb_sad_best_match;
    localparam int MD = 16;
    localparam int SR = 8;
    localparam int NC = (2 * SR + 1) * (2 * SR + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_pass   = 0;
    int n_total  = 0;
    int done_cnt = 0;
    int d0       = 0;

    sad_best_match_if #(.MACRO_DIM(MD), .SEARCH_RANGE(SR)) bus ();

    sad_best_match #(.MACRO_DIM(MD), .SEARCH_RANGE(SR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count done pulses over the whole run
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Watchdog so the run always ends
    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Row contents for each scenario (mode) and candidate index (raster order)
    function automatic logic [MD*8-1:0] row_data(input int mode, input int cand, input int row);
        logic [MD*8-1:0] d;
        d = '0;
        case (mode)
            0: for (int c = 0; c < MD; c++) d[8*c +: 8] = (cand == 63) ? 8'd0 : 8'd1;
            1: for (int c = 0; c < MD; c++) d[8*c +: 8] = 8'd255;
            2: begin
                if (cand == 0)        d[8*row +: 8] = 8'd1;
                else if (cand == 100) d[8*((row + 5) % MD) +: 8] = 8'd1;
                else for (int c = 0; c < MD; c++) d[8*c +: 8] = 8'd1;
            end
            3: for (int c = 0; c < MD; c++) d[8*c +: 8] = (cand == NC - 1) ? 8'd1 : 8'd2;
            default: d = '0;
        endcase
        return d;
    endfunction

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Feed every row of a search; optional random gaps with start pulses,
    // optional early return in the middle of candidate abort_cand
    task automatic feed(input int mode, input bit gaps, input int abort_cand);
        for (int cand = 0; cand < NC; cand++) begin
            for (int row = 0; row < MD; row++) begin
                if (cand == abort_cand && row == 8) return;
                if (gaps) begin
                    while ($urandom_range(0, 99) < 30) begin
                        bus.ad_valid = 1'b0;
                        bus.ad_in    = {$urandom, $urandom, $urandom, $urandom};
                        bus.start    = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                    end
                end
                bus.start    = 1'b0;
                bus.ad_valid = 1'b1;
                bus.ad_in    = row_data(mode, cand, row);
                @(posedge clk); #1;
            end
        end
        bus.ad_valid = 1'b0;
        bus.ad_in    = '0;
    endtask

    // Called just after the edge that accepted the final row (FLUSH cycle)
    task automatic check_end(input string tag, input int esad, input int emx,
                             input int emy, input int dref, input bit noisy);
        check({tag, ".flush_busy"}, int'(bus.busy), 1);
        check({tag, ".flush_done"}, int'(bus.done), 0);
        if (noisy) begin
            bus.ad_valid = 1'b1;
            bus.ad_in    = '0;
            bus.start    = 1'b1;
        end
        @(posedge clk); #1;
        bus.ad_valid = 1'b0;
        bus.start    = 1'b0;
        check({tag, ".done"}, int'(bus.done), 1);
        check({tag, ".busy"}, int'(bus.busy), 0);
        check({tag, ".sad"},  int'(bus.best_sad), esad);
        check({tag, ".mvx"},  int'(bus.best_mvx), emx);
        check({tag, ".mvy"},  int'(bus.best_mvy), emy);
        @(posedge clk); #1;
        check({tag, ".done_clr"}, int'(bus.done), 0);
        check({tag, ".done_cnt"}, done_cnt - dref, 1);
        check({tag, ".hold_sad"}, int'(bus.best_sad), esad);
        check({tag, ".hold_mvx"}, int'(bus.best_mvx), emx);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.ad_valid = 1'b0;
        bus.ad_in    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", int'(bus.busy), 0);
        check("rst.done", int'(bus.done), 0);
        check("rst.sad",  int'(bus.best_sad), 65535);
        check("rst.mvx",  int'(bus.best_mvx), 0);
        check("rst.mvy",  int'(bus.best_mvy), 0);
        rst_n = 1'b1;

        // ad_valid while idle must be ignored
        bus.ad_valid = 1'b1;
        bus.ad_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        bus.ad_valid = 1'b0;
        check("idle.busy", int'(bus.busy), 0);

        // Scenario 1: single zero-SAD candidate at (12,3)
        d0 = done_cnt;
        do_start();
        check("s1.start_busy", int'(bus.busy), 1);
        feed(0, 1'b0, -1);
        check_end("s1", 0, 4, -5, d0, 1'b0);

        // Scenario 2: all ADs 255, first candidate wins the tie
        repeat (3) @(posedge clk);
        #1;
        check("s1.idle_hold", int'(bus.best_sad), 0);
        d0 = done_cnt;
        do_start();
        check("s2.reinit_sad", int'(bus.best_sad), 65535);
        feed(1, 1'b0, -1);
        check_end("s2", 65280, -8, -8, d0, 1'b0);

        // Scenario 3: candidates 0 and 100 tie at 16
        d0 = done_cnt;
        do_start();
        feed(2, 1'b0, -1);
        check_end("s3", 16, -8, -8, d0, 1'b0);

        // Scenario 4: scenario 1 data with gaps, start pulses, FLUSH noise
        d0 = done_cnt;
        do_start();
        feed(0, 1'b1, -1);
        check_end("s4", 0, 4, -5, d0, 1'b1);

        // Scenario 5: reset in the middle of candidate 50, then fresh search
        d0 = done_cnt;
        do_start();
        feed(1, 1'b0, 50);
        rst_n = 1'b0;
        #2;
        check("s5.rst_busy", int'(bus.busy), 0);
        check("s5.rst_done", int'(bus.done), 0);
        check("s5.rst_sad",  int'(bus.best_sad), 65535);
        check("s5.rst_mvx",  int'(bus.best_mvx), 0);
        repeat (3) @(posedge clk);
        #1;
        check("s5.no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        d0 = done_cnt;
        do_start();
        feed(0, 1'b0, -1);
        check_end("s5", 0, 4, -5, d0, 1'b0);

        // Scenario 6: back-to-back, higher-SAD second search
        d0 = done_cnt;
        do_start();
        feed(0, 1'b0, -1);
        check_end("s6a", 0, 4, -5, d0, 1'b0);
        d0 = done_cnt;
        do_start();
        check("s6b.reinit_sad", int'(bus.best_sad), 65535);
        check("s6b.reinit_mvx", int'(bus.best_mvx), 0);
        feed(3, 1'b0, -1);
        check_end("s6b", 256, 8, 8, d0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
